// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, keypad layout decode and debounce state encoding shared by the
// keypad scanner and the digit editor.
`default_nettype none

package keypad_pkg;

    // Sixteen physical keys plus NONE/MULTI need a fifth code bit.
    localparam int KEY_W = 5;
    typedef logic [KEY_W-1:0] key_t;

    localparam key_t KEY_0     = 5'd0;
    localparam key_t KEY_1     = 5'd1;
    localparam key_t KEY_2     = 5'd2;
    localparam key_t KEY_3     = 5'd3;
    localparam key_t KEY_4     = 5'd4;
    localparam key_t KEY_5     = 5'd5;
    localparam key_t KEY_6     = 5'd6;
    localparam key_t KEY_7     = 5'd7;
    localparam key_t KEY_8     = 5'd8;
    localparam key_t KEY_9     = 5'd9;
    localparam key_t KEY_A     = 5'd10;
    localparam key_t KEY_B     = 5'd11;
    localparam key_t KEY_C     = 5'd12;
    localparam key_t KEY_D     = 5'd13;
    localparam key_t KEY_STAR  = 5'd14;
    localparam key_t KEY_HASH  = 5'd15;
    localparam key_t KEY_NONE  = 5'd16;
    localparam key_t KEY_MULTI = 5'd17;

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_PRESS_CNT = 2'd1,
        DB_HELD      = 2'd2,
        DB_REL_CNT   = 2'd3
    } db_state_e;

    // Layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, columns left to right.
    function automatic key_t decode_rc(input logic [1:0] c, input logic [1:0] r);
        key_t k;
        case ({r, c})
            4'h0: k = KEY_1;    4'h1: k = KEY_2;  4'h2: k = KEY_3;    4'h3: k = KEY_A;
            4'h4: k = KEY_4;    4'h5: k = KEY_5;  4'h6: k = KEY_6;    4'h7: k = KEY_B;
            4'h8: k = KEY_7;    4'h9: k = KEY_8;  4'hA: k = KEY_9;    4'hB: k = KEY_C;
            4'hC: k = KEY_STAR; 4'hD: k = KEY_0;  4'hE: k = KEY_HASH; default: k = KEY_D;
        endcase
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: drives keypad columns, synchronises rows, assembles full scans and
// debounces them into one key_evt pulse per press.
`default_nettype none

module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_evt,
    output key_t       key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       row_m_q, row_s_q;
    logic             acc_any_q, acc_multi_q;
    key_t             acc_code_q;
    logic             any_d, multi_d;
    key_t             code_d;
    logic             slot_end, scan_done;
    key_t             scan_code;

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_t             cand_q, cand_d;
    logic             evt_q, evt_d;

    assign slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign scan_done = slot_end && (col_idx_q == 2'd3);
    assign col       = ~(4'b0001 << col_idx_q);

    // Fold this slot's active rows into the running scan result.
    always_comb begin
        any_d   = acc_any_q;
        multi_d = acc_multi_q;
        code_d  = acc_code_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_s_q[r]) begin
                if (any_d) multi_d = 1'b1;
                any_d  = 1'b1;
                code_d = decode_rc(col_idx_q, 2'(r));
            end
        end
        scan_code = !any_d ? KEY_NONE : (multi_d ? KEY_MULTI : code_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            row_m_q     <= 4'hF;
            row_s_q     <= 4'hF;
            acc_any_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= KEY_NONE;
        end else begin
            row_m_q <= row;
            row_s_q <= row_m_q;
            if (slot_end) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) begin
                    acc_any_q   <= 1'b0;
                    acc_multi_q <= 1'b0;
                    acc_code_q  <= KEY_NONE;
                end else begin
                    acc_any_q   <= any_d;
                    acc_multi_q <= multi_d;
                    acc_code_q  <= code_d;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            cand_q  <= KEY_NONE;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            evt_q   <= evt_d;
        end
    end

    // The first scan showing a code already counts as one of DEBOUNCE_SCANS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        evt_d   = 1'b0;
        if (scan_done) begin
            case (state_q)
                DB_IDLE: begin
                    if (scan_code != KEY_NONE && scan_code != KEY_MULTI) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d = DB_HELD;
                            evt_d   = 1'b1;
                        end else begin
                            state_d = DB_PRESS_CNT;
                        end
                    end
                end
                DB_PRESS_CNT: begin
                    if (scan_code == KEY_NONE || scan_code == KEY_MULTI) begin
                        state_d = DB_IDLE;
                    end else if (scan_code != cand_q) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_q >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
                        state_d = DB_HELD;
                        evt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DB_HELD: begin
                    if (scan_code == KEY_NONE) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (DEBOUNCE_SCANS <= 1) ? DB_IDLE : DB_REL_CNT;
                    end
                end
                DB_REL_CNT: begin
                    if (scan_code != KEY_NONE) begin
                        state_d = DB_HELD;
                    end else if (cnt_q >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
                        state_d = DB_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = DB_IDLE;
            endcase
        end
    end

    assign key_evt  = evt_q;
    assign key_code = cand_q;

endmodule

`default_nettype wire

// File: rtl/keypad_digit_editor.sv
// +----------------------------------------------------------------------------------------+
// | keypad_digit_editor: keypad-driven N-digit BCD editor with commit/cancel and preload.  |
// | Revision: 1.0                                                                          |
// +----------------------------------------------------------------------------------------+
`default_nettype none

module keypad_digit_editor
    import keypad_pkg::*;
#(
    parameter int                      NUM_DIGITS     = 6,
    parameter int                      SCAN_DIV       = 100_000,
    parameter int                      DEBOUNCE_SCANS = 20,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX      = 24'h295959,
    parameter int                      AUTO_ADVANCE   = 1,
    parameter int                      HOUR_CHECK     = 1,
    localparam int                     CW             = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [3:0]              row,
    output logic [3:0]              col,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [CW-1:0]           cursor,
    output logic                    key_valid,
    output key_t                    key_code,
    output logic                    commit,
    output logic                    cancel,
    output logic                    err
);

    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] NEXT = CW'(NUM_DIGITS - 2);

    logic                    key_evt;
    key_t                    evt_code;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d, snap_q, snap_d;
    logic [CW-1:0]           cursor_q, cursor_d, cur_inc, cur_dec;
    logic                    key_valid_q, commit_q, commit_d, cancel_q, cancel_d, err_q, err_d;
    key_t                    key_code_q;
    logic [3:0]              val, cur_max;
    logic                    hour_ok, clamp;

    keypad_scan_debounce #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_evt  (key_evt),
        .key_code (evt_code)
    );

    assign val     = evt_code[3:0];
    assign cur_max = DIGIT_MAX[4*cursor_q +: 4];
    assign cur_inc = (cursor_q == LAST) ? '0 : cursor_q + CW'(1);
    assign cur_dec = (cursor_q == '0) ? LAST : cursor_q - CW'(1);

    // Hour rule: a leading 2 caps the next digit at 3, and typing the 2 clamps it.
    always_comb begin
        hour_ok = 1'b1;
        clamp   = 1'b0;
        if (HOUR_CHECK != 0) begin
            if (cursor_q == NEXT && digits_q[4*(NUM_DIGITS-1) +: 4] == 4'd2 && val > 4'd3)
                hour_ok = 1'b0;
            if (cursor_q == LAST && val == 4'd2 && digits_q[4*(NUM_DIGITS-2) +: 4] > 4'd3)
                clamp = 1'b1;
        end
    end

    always_comb begin
        digits_d = digits_q;
        snap_d   = snap_q;
        cursor_d = cursor_q;
        commit_d = 1'b0;
        cancel_d = 1'b0;
        err_d    = 1'b0;
        if (load) begin
            digits_d = digits_in;
            snap_d   = digits_in;
            cursor_d = LAST;
        end else if (key_evt && en) begin
            if (evt_code <= KEY_9) begin
                if (val <= cur_max && hour_ok) begin
                    digits_d[4*cursor_q +: 4] = val;
                    if (clamp) digits_d[4*(NUM_DIGITS-2) +: 4] = 4'd3;
                    if (AUTO_ADVANCE != 0) cursor_d = cur_dec;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (evt_code)
                    KEY_STAR: cursor_d = cur_inc;
                    KEY_HASH: cursor_d = cur_dec;
                    KEY_A: begin
                        snap_d   = digits_q;
                        commit_d = 1'b1;
                    end
                    KEY_B: begin
                        digits_d = snap_q;
                        cursor_d = LAST;
                        cancel_d = 1'b1;
                    end
                    KEY_C: begin
                        digits_d = '0;
                        cursor_d = LAST;
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            digits_q    <= '0;
            snap_q      <= '0;
            cursor_q    <= LAST;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_NONE;
            commit_q    <= 1'b0;
            cancel_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            snap_q      <= snap_d;
            cursor_q    <= cursor_d;
            key_valid_q <= key_evt;
            commit_q    <= commit_d;
            cancel_q    <= cancel_d;
            err_q       <= err_d;
            if (key_evt) key_code_q <= evt_code;
        end
    end

    assign digits    = digits_q;
    assign cursor    = cursor_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign commit    = commit_q;
    assign cancel    = cancel_q;
    assign err       = err_q;

endmodule

`default_nettype wire
